// File: rtl/execute_shift_multi.sv
// Multi-cycle shifter for SLL/SRL/SRA (and optional ROL/ROR), shifting at most STEP bits per cycle.
// Latency: result and valid appear max(1, ceil(shamt/STEP)) cycles after the accepting edge.
// Backpressure: ready is low while BUSY; read_valid seen then is dropped. Define EXECUTE_SHIFT_ROTATE_EN to add rotates.
module execute_shift_multi #(
  parameter int XLEN = 32,
  parameter int STEP = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [6:0]      decode_opcode,
  input  logic [2:0]      decode_funct3,
  input  logic [6:0]      decode_funct7,
  input  logic [31:0]     decode_imm,
  input  logic [XLEN-1:0] read_rs1_val,
  input  logic [XLEN-1:0] read_rs2_val,
  input  logic            read_valid,
  output logic            ready,
  output logic            processing,
  output logic            valid,
  output logic [XLEN-1:0] rd_val_out
);

  localparam int SHW = $clog2(XLEN);

  // One extra bit so that STEP == XLEN still fits in the per-cycle amount.
  typedef logic [SHW:0] amt_t;
  localparam amt_t STEP_A = amt_t'(STEP);

  localparam logic [6:0] OPC_IMM = 7'b0010011;
  localparam logic [6:0] OPC_REG = 7'b0110011;

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR} op_t;

  state_t            state_q;
  op_t               op_q;
  logic [XLEN-1:0]   val_q;
  logic [SHW-1:0]    rem_q;
  logic              sign_q;
  logic              valid_q;
  logic [XLEN-1:0]   rd_val_q;

  logic              is_imm;
  logic              is_reg;
  logic [6:0]        f7_cmp;
  op_t               dec_op;
  logic [SHW-1:0]    dec_shamt;

  amt_t              rem_ext;
  amt_t              amt;
  logic              last_step;
  logic [2*XLEN-1:0] dbl_l;
  logic [2*XLEN-1:0] dbl_r;
  logic [XLEN-1:0]   step_val_d;

  // Upper operand bits are architecturally ignored by a shift.
  logic unused_bits;
  assign unused_bits = ^{decode_imm[31:SHW], read_rs2_val[XLEN-1:SHW]};

  // Decode the op and pick the shift amount source.
  always_comb begin
    is_imm = (decode_opcode == OPC_IMM);
    is_reg = (decode_opcode == OPC_REG);
    f7_cmp = decode_funct7;
    // On RV64 the immediate form carries shamt[5] in funct7[0].
    if (XLEN == 64 && is_imm) f7_cmp[0] = 1'b0;
    dec_op = OP_NONE;
    if (is_imm || is_reg) begin
      case ({f7_cmp, decode_funct3})
        10'b0000000_001: dec_op = OP_SLL;
        10'b0000000_101: dec_op = OP_SRL;
        10'b0100000_101: dec_op = OP_SRA;
`ifdef EXECUTE_SHIFT_ROTATE_EN
        10'b0110000_001: dec_op = is_reg ? OP_ROL : OP_NONE;
        10'b0110000_101: dec_op = OP_ROR;
`endif
        default:         dec_op = OP_NONE;
      endcase
    end
    dec_shamt = is_imm ? decode_imm[SHW-1:0] : read_rs2_val[SHW-1:0];
  end

  // One shift step of at most STEP bits on the working value.
  always_comb begin
    rem_ext    = {1'b0, rem_q};
    last_step  = (rem_ext <= STEP_A);
    amt        = last_step ? rem_ext : STEP_A;
    dbl_l      = '0;
    dbl_r      = '0;
    step_val_d = val_q;
    case (op_q)
      OP_SLL: step_val_d = val_q << amt;
      OP_SRL: step_val_d = val_q >> amt;
      OP_SRA: begin
        // Fill from the sign captured at acceptance, not the running MSB.
        dbl_r      = {{XLEN{sign_q}}, val_q} >> amt;
        step_val_d = dbl_r[XLEN-1:0];
      end
`ifdef EXECUTE_SHIFT_ROTATE_EN
      OP_ROL: begin
        dbl_l      = {val_q, val_q} << amt;
        step_val_d = dbl_l[2*XLEN-1:XLEN];
      end
      OP_ROR: begin
        dbl_r      = {val_q, val_q} >> amt;
        step_val_d = dbl_r[XLEN-1:0];
      end
`endif
      default: step_val_d = val_q;
    endcase
  end

  // Control FSM plus operand/result registers; valid is a one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NONE;
      val_q    <= '0;
      rem_q    <= '0;
      sign_q   <= 1'b0;
      valid_q  <= 1'b0;
      rd_val_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (read_valid && !flush && (dec_op != OP_NONE)) begin
            val_q   <= read_rs1_val;
            rem_q   <= dec_shamt;
            op_q    <= dec_op;
            sign_q  <= read_rs1_val[XLEN-1];
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (flush) begin
            // Abort: result register deliberately left untouched.
            rem_q   <= '0;
            state_q <= S_IDLE;
          end else if (last_step) begin
            rd_val_q <= step_val_d;
            valid_q  <= 1'b1;
            rem_q    <= '0;
            state_q  <= S_IDLE;
          end else begin
            val_q <= step_val_d;
            rem_q <= rem_q - amt[SHW-1:0];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign processing = (state_q == S_BUSY);
  assign valid      = valid_q;
  assign rd_val_out = rd_val_q;

endmodule

// File: tb/tb_execute_shift_multi.sv
// Directed bench: a 32-bit/STEP=8 instance and a 64-bit/STEP=16 instance share clock, reset and decode fields.
// Each directed step checks latency, result, the one-cycle valid pulse and the IDLE/BUSY handshake.
// Waits on valid are bounded; a timeout shows up as a wrong latency.
module tb_execute_shift_multi;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;
  logic [31:0] rs1_32, rs2_32;
  logic [63:0] rs1_64, rs2_64;
  logic        rv32, rv64;
  logic        ready32, proc32, valid32;
  logic        ready64, proc64, valid64;
  logic [31:0] rd32;
  logic [63:0] rd64;

  int checks = 0;
  int errors = 0;
  int lat;
  int cnt;

  execute_shift_multi #(.XLEN(32), .STEP(8)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .decode_opcode(opc), .decode_funct3(f3), .decode_funct7(f7), .decode_imm(imm),
    .read_rs1_val(rs1_32), .read_rs2_val(rs2_32), .read_valid(rv32),
    .ready(ready32), .processing(proc32), .valid(valid32), .rd_val_out(rd32)
  );

  execute_shift_multi #(.XLEN(64), .STEP(16)) dut64 (
    .clk(clk), .reset(reset), .flush(flush),
    .decode_opcode(opc), .decode_funct3(f3), .decode_funct7(f7), .decode_imm(imm),
    .read_rs1_val(rs1_64), .read_rs2_val(rs2_64), .read_valid(rv64),
    .ready(ready64), .processing(proc64), .valid(valid64), .rd_val_out(rd64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one operation for exactly one cycle; returns at the negedge after the accepting edge.
  task automatic drive(input bit b64, input logic [6:0] o, input logic [2:0] fn3, input logic [6:0] fn7,
                       input logic [31:0] im, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    opc = o; f3 = fn3; f7 = fn7; imm = im;
    rs1_32 = a[31:0]; rs2_32 = b[31:0]; rs1_64 = a; rs2_64 = b;
    if (b64) rv64 = 1'b1; else rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0; rv64 = 1'b0;
  endtask

  // Cycles from the accepting edge to the valid edge, bounded.
  task automatic wait_valid(input bit b64, output int l);
    l = 0;
    do begin
      @(negedge clk);
      l++;
    end while (!(b64 ? valid64 : valid32) && l < 40);
  endtask

  task automatic count_valids(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (valid32 || valid64) c++;
    end
  endtask

  task automatic run(input string tag, input bit b64, input logic [6:0] o, input logic [2:0] fn3,
                     input logic [6:0] fn7, input logic [31:0] im, input logic [63:0] a,
                     input logic [63:0] b, input int exp_lat, input logic [63:0] exp_val);
    int l;
    drive(b64, o, fn3, fn7, im, a, b);
    chk({tag, "_busy"}, b64 ? proc64 : proc32, 1'b1);
    wait_valid(b64, l);
    chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
    chk({tag, "_val"}, b64 ? rd64 : {32'h0, rd32}, exp_val);
    @(negedge clk);
    chk({tag, "_pulse"}, b64 ? valid64 : valid32, 1'b0);
    chk({tag, "_hold"}, b64 ? rd64 : {32'h0, rd32}, exp_val);
    chk({tag, "_rdy"}, b64 ? ready64 : ready32, 1'b1);
  endtask

  localparam logic [6:0] OI = 7'b0010011;
  localparam logic [6:0] OR = 7'b0110011;

  initial begin
    reset = 1'b1; flush = 1'b0; opc = '0; f3 = '0; f7 = '0; imm = '0;
    rs1_32 = '0; rs2_32 = '0; rs1_64 = '0; rs2_64 = '0; rv32 = 1'b0; rv64 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", ready32, 1'b1);
    chk("rst_proc", proc32, 1'b0);
    chk("rst_valid", valid32, 1'b0);
    chk("rst_rd", rd32, 32'h0);
    chk("rst_rd64", rd64, 64'h0);
    reset = 1'b0;

    // Main shift patterns.
    run("slli20", 0, OI, 3'b001, 7'b0000000, 32'd20, 64'h1, 64'h0, 3, 64'h00100000);
    run("sra31", 0, OR, 3'b101, 7'b0100000, 32'd0, 64'h80000000, 64'd31, 4, 64'hFFFFFFFF);
    run("srl31", 0, OR, 3'b101, 7'b0000000, 32'd0, 64'h80000000, 64'd31, 4, 64'h00000001);
    run("srl0", 0, OR, 3'b101, 7'b0000000, 32'd0, 64'h12345678, 64'h20, 1, 64'h12345678);
    run("srai4", 0, OI, 3'b101, 7'b0100000, 32'd4, 64'hF0000000, 64'h0, 1, 64'hFF000000);
    run("sll8", 0, OR, 3'b001, 7'b0000000, 32'd0, 64'h000000A5, 64'd8, 1, 64'h0000A500);

    // read_valid while BUSY is dropped.
    drive(0, OR, 3'b001, 7'b0000000, 32'd0, 64'h3, 64'd16);
    opc = OR; f3 = 3'b101; f7 = 7'b0000000; rs1_32 = 32'hAAAA5555; rs2_32 = 32'd0; rv32 = 1'b1;
    @(negedge clk);
    rv32 = 1'b0;
    chk("busy_rv_novalid", valid32, 1'b0);
    @(negedge clk);
    chk("busy_rv_valid", valid32, 1'b1);
    chk("busy_rv_val", rd32, 32'h00030000);
    count_valids(4, cnt);
    chk("busy_rv_extra", 64'(cnt), 64'd0);

    // Unrecognised encodings: ADD and the MUL funct7.
    drive(0, OR, 3'b000, 7'b0000000, 32'd0, 64'h1, 64'h1);
    chk("add_ready", ready32, 1'b1);
    drive(0, OR, 3'b001, 7'b0000001, 32'd0, 64'h1, 64'h1);
    chk("mul_ready", ready32, 1'b1);
    count_valids(4, cnt);
    chk("unrec_novalid", 64'(cnt), 64'd0);
    chk("unrec_hold", rd32, 32'h00030000);

    // Flush on the second BUSY cycle of a 3-cycle SLL.
    drive(0, OR, 3'b001, 7'b0000000, 32'd0, 64'h1, 64'd24);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_valid", valid32, 1'b0);
    chk("flush_idle", ready32, 1'b1);
    chk("flush_hold", rd32, 32'h00030000);
    count_valids(5, cnt);
    chk("flush_novalid", 64'(cnt), 64'd0);

    // Flush in IDLE blocks acceptance.
    @(negedge clk);
    opc = OR; f3 = 3'b001; f7 = 7'b0000000; rs1_32 = 32'h1; rs2_32 = 32'd1; rv32 = 1'b1; flush = 1'b1;
    @(negedge clk);
    rv32 = 1'b0; flush = 1'b0;
    chk("flush_idle_rdy", ready32, 1'b1);
    chk("flush_idle_proc", proc32, 1'b0);
    count_valids(3, cnt);
    chk("flush_idle_novalid", 64'(cnt), 64'd0);

    // Rotates exist only when the build enables them.
`ifdef EXECUTE_SHIFT_ROTATE_EN
    run("ror4", 0, OR, 3'b101, 7'b0110000, 32'd0, 64'h000000F1, 64'd4, 1, 64'h1000000F);
    run("rol9", 0, OR, 3'b001, 7'b0110000, 32'd0, 64'h80000001, 64'd9, 2, 64'h00000300);
`else
    drive(0, OR, 3'b101, 7'b0110000, 32'd0, 64'h000000F1, 64'd4);
    chk("ror_off_ready", ready32, 1'b1);
    drive(0, OR, 3'b001, 7'b0110000, 32'd0, 64'h80000001, 64'd9);
    chk("rol_off_ready", ready32, 1'b1);
    count_valids(4, cnt);
    chk("rot_off_novalid", 64'(cnt), 64'd0);
`endif

    // 64-bit datapath, STEP=16; funct7[0] is shamt[5] for the immediate form.
    run("srai63_64", 1, OI, 3'b101, 7'b0100000, 32'd63, 64'h8000000000000000, 64'h0, 4, 64'hFFFFFFFFFFFFFFFF);
    run("slli40_64", 1, OI, 3'b001, 7'b0000001, 32'd40, 64'h1, 64'h0, 3, 64'h0000010000000000);

    // Reset in the middle of an SRA.
    run("pre_rst", 0, OR, 3'b001, 7'b0000000, 32'd0, 64'h1, 64'd4, 1, 64'h10);
    drive(0, OR, 3'b101, 7'b0100000, 32'd0, 64'h80000000, 64'd31);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", ready32, 1'b1);
    chk("midrst_proc", proc32, 1'b0);
    chk("midrst_rd", rd32, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    count_valids(6, cnt);
    chk("midrst_novalid", 64'(cnt), 64'd0);
    chk("midrst_rd_after", rd32, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
